// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed seven-segment driver showing a 32-bit value as hex.
// The value is latched once per frame so a frame never shows two results.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data,
  output logic [6:0]  seg,
  output logic [7:0]  ans,
  output logic        frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_shadow;
  logic [6:0]    r_seg;
  logic [7:0]    r_ans;
  logic          r_frame_done;

  logic          w_tick;
  logic          w_wrap;
  logic [4:0]    w_sh;
  logic [3:0]    w_nib;
  logic [31:0]   w_upper;
  logic          w_blank;
  logic [6:0]    w_hex;

  assign w_tick  = (r_presc == PW'(REFRESH_DIV - 1));
  assign w_wrap  = w_tick && (r_idx == 3'd7);
  assign w_sh    = {r_idx, 2'b00};
  assign w_nib   = r_shadow[w_sh +: 4];
  assign w_upper = r_shadow >> w_sh;
  assign w_blank = BLANK_LZ && (r_idx != 3'd0)
                && (w_upper == 32'h0);

  always_comb begin
    w_hex = 7'h7F;
    unique case (w_nib)
      4'h0: w_hex = 7'h40;
      4'h1: w_hex = 7'h79;
      4'h2: w_hex = 7'h24;
      4'h3: w_hex = 7'h30;
      4'h4: w_hex = 7'h19;
      4'h5: w_hex = 7'h12;
      4'h6: w_hex = 7'h02;
      4'h7: w_hex = 7'h78;
      4'h8: w_hex = 7'h00;
      4'h9: w_hex = 7'h10;
      4'hA: w_hex = 7'h08;
      4'hB: w_hex = 7'h03;
      4'hC: w_hex = 7'h46;
      4'hD: w_hex = 7'h21;
      4'hE: w_hex = 7'h06;
      4'hF: w_hex = 7'h0E;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc      <= '0;
      r_idx        <= 3'd0;
      r_shadow     <= 32'h0;
      r_seg        <= 7'h7F;
      r_ans        <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      r_presc      <= w_tick ? '0 : r_presc + PW'(1);
      r_frame_done <= w_wrap;
      if (w_tick)
        r_idx <= r_idx + 3'd1;
      if (w_wrap)
        r_shadow <= data;
      // outputs reflect the current idx, so they trail it by one clock
      if (w_blank) begin
        r_seg <= 7'h7F;
        r_ans <= 8'hFF;
      end else begin
        r_seg <= w_hex;
        r_ans <= ~(8'b1 << r_idx);
      end
    end
  end

  assign seg        = r_seg;
  assign ans        = r_ans;
  assign frame_done = r_frame_done;

endmodule
